// File: rtl/uart_rx_frame_assembler_pkg.sv
// Shared types for the UART receive side.
package uart_rx_frame_assembler_pkg;

   // Frame assembler FSM states. The Err* pair mirrors Ack/WaitLow but marks a dropped byte.
   typedef enum logic [2:0] {
      StWaitByte,
      StAck,
      StWaitLow,
      StErrAck,
      StErrLow
   } rx_asm_state_t;

endpackage

// File: rtl/uart_rx_frame_assembler_if.sv
// Receiver-side handshake plus assembled-frame outputs of the frame assembler.
interface uart_rx_frame_assembler_if #(
   parameter int unsigned BYTE_W = 8,
   parameter int unsigned OUT_W  = 8,
   parameter int unsigned CNT_W  = 2
);
   logic              rx_interrupt;
   logic              rx_error;
   logic [BYTE_W-1:0] rx_data;
   logic              clear_interrupt;
   logic              frame_valid;
   logic [OUT_W-1:0]  frame_data;
   logic              frame_error;
   logic              busy;
   logic [CNT_W-1:0]  chunk_count;

   // Assembler side.
   modport slave (
      input  rx_interrupt, rx_error, rx_data,
      output clear_interrupt, frame_valid, frame_data, frame_error, busy, chunk_count
   );

   // Receiver / consumer side.
   modport master (
      output rx_interrupt, rx_error, rx_data,
      input  clear_interrupt, frame_valid, frame_data, frame_error, busy, chunk_count
   );
endinterface

// File: rtl/uart_rx_frame_assembler_rx_timeout_timer.sv
// Inter-byte timeout counter. Expires on the enabled cycle that would bring the count to
// TIMEOUT_CYC; a TIMEOUT_CYC of 0 removes the counter entirely.
module rx_timeout_timer #(
   parameter int unsigned TIMEOUT_CYC = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_load,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   if (TIMEOUT_CYC == 0) begin : g_tieoff
      logic w_unused;
      assign w_unused  = ^{clk, reset, i_load, i_clear, i_enable};
      assign o_expired = 1'b0;
   end else begin : g_timer
      localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
      logic [TW-1:0] r_cnt;

      // Count idle cycles; any capture or frame drop restarts from zero.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_cnt <= '0;
         end else if (i_load || i_clear) begin
            r_cnt <= '0;
         end else if (i_enable) begin
            r_cnt <= r_cnt + TW'(1);
         end
      end

      assign o_expired = i_enable && (r_cnt == TW'(TIMEOUT_CYC - 1));
   end

endmodule

// File: rtl/uart_rx_frame_assembler.sv
// Packs the low CHUNK_W bits of NUM_CHUNKS received bytes into one frame word, acknowledging
// every byte to the receiver and dropping partial frames on receive errors or timeouts.
module uart_rx_frame_assembler
   import uart_rx_frame_assembler_pkg::*;
#(
   parameter int unsigned BYTE_W      = 8,
   parameter int unsigned CHUNK_W     = 4,
   parameter int unsigned NUM_CHUNKS  = 2,
   parameter bit          MSB_FIRST   = 1'b1,
   parameter int unsigned TIMEOUT_CYC = 0
) (
   input logic                        clk,
   input logic                        reset,
   uart_rx_frame_assembler_if.slave   bus
);

   localparam int unsigned OUT_W = CHUNK_W * NUM_CHUNKS;
   localparam int unsigned CNT_W = $clog2(NUM_CHUNKS + 1);

   rx_asm_state_t      r_state;
   rx_asm_state_t      w_state_next;
   logic [OUT_W-1:0]   r_shift;
   logic [OUT_W-1:0]   r_frame_data;
   logic [CNT_W-1:0]   r_count;
   logic               r_frame_valid;
   logic               r_frame_error;

   logic [CHUNK_W-1:0] w_chunk;
   logic [OUT_W-1:0]   w_shift_next;
   logic               w_capture;
   logic               w_rx_err;
   logic               w_last;
   logic               w_timer_en;
   logic               w_expired;
   logic               w_timeout;
   logic               w_drop;
   logic               w_clear_interrupt;
   logic [BYTE_W-1:0]  w_unused_rx_data;

   // Upper rx_data bits are deliberately ignored.
   assign w_unused_rx_data = bus.rx_data;
   assign w_chunk          = bus.rx_data[CHUNK_W-1:0];

   assign w_capture  = (r_state == StWaitByte) && bus.rx_interrupt && !bus.rx_error;
   assign w_rx_err   = (r_state == StWaitByte) && bus.rx_interrupt && bus.rx_error;
   assign w_last     = (r_count == CNT_W'(NUM_CHUNKS - 1));
   assign w_timer_en = (r_state == StWaitByte) && (r_count != '0);
   // A pending byte takes priority over an expiring timer.
   assign w_timeout  = w_expired && !bus.rx_interrupt;
   assign w_drop     = w_rx_err || w_timeout;

   // MSB-first shifts left (new chunk lowest); LSB-first shifts right (new chunk highest).
   assign w_shift_next = MSB_FIRST ? ((r_shift << CHUNK_W) | OUT_W'(w_chunk))
                                   : ((r_shift >> CHUNK_W) | (OUT_W'(w_chunk) << (OUT_W - CHUNK_W)));

   rx_timeout_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_capture),
      .i_clear   (w_drop),
      .i_enable  (w_timer_en),
      .o_expired (w_expired)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= StWaitByte;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state: ack each interrupt once, then wait for the receiver to drop it.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StWaitByte: begin
            if (bus.rx_interrupt) begin
               w_state_next = bus.rx_error ? StErrAck : StAck;
            end
         end
         StAck:    w_state_next = StWaitLow;
         StErrAck: w_state_next = StErrLow;
         StWaitLow, StErrLow: begin
            if (!bus.rx_interrupt) begin
               w_state_next = StWaitByte;
            end
         end
         default:  w_state_next = StWaitByte;
      endcase
   end

   // FSM outputs: clear pulse is a one-cycle Moore output of the ack states.
   always_comb begin
      w_clear_interrupt = 1'b0;
      unique case (r_state)
         StAck, StErrAck: w_clear_interrupt = 1'b1;
         default:         w_clear_interrupt = 1'b0;
      endcase
   end

   // Chunk collection, frame completion and drop handling.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift       <= '0;
         r_frame_data  <= '0;
         r_count       <= '0;
         r_frame_valid <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_frame_valid <= 1'b0;
         r_frame_error <= 1'b0;
         if (w_capture) begin
            if (w_last) begin
               r_frame_data  <= w_shift_next;
               r_frame_valid <= 1'b1;
               r_count       <= '0;
               r_shift       <= '0;
            end else begin
               r_shift <= w_shift_next;
               r_count <= r_count + CNT_W'(1);
            end
         end else if (w_drop) begin
            r_shift       <= '0;
            r_count       <= '0;
            r_frame_error <= 1'b1;
         end
      end
   end

   assign bus.clear_interrupt = w_clear_interrupt;
   assign bus.frame_valid     = r_frame_valid;
   assign bus.frame_data      = r_frame_data;
   assign bus.frame_error     = r_frame_error;
   assign bus.busy            = (r_count != '0);
   assign bus.chunk_count     = r_count;

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Three assemblers share one receiver stream: A = defaults, B = 4 chunks MSB-first with a
// 10-cycle timeout, C = 4 chunks LSB-first. Each is checked against a frame-level model.
module tb_uart_rx_frame_assembler;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_int = 1'b0;
   logic       rx_err = 1'b0;
   logic [7:0] rx_data = 8'h00;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_rx_frame_assembler_if #(.BYTE_W(8), .OUT_W(8),  .CNT_W(2)) if_a ();
   uart_rx_frame_assembler_if #(.BYTE_W(8), .OUT_W(16), .CNT_W(3)) if_b ();
   uart_rx_frame_assembler_if #(.BYTE_W(8), .OUT_W(16), .CNT_W(3)) if_c ();

   assign if_a.rx_interrupt = rx_int;
   assign if_a.rx_error     = rx_err;
   assign if_a.rx_data      = rx_data;
   assign if_b.rx_interrupt = rx_int;
   assign if_b.rx_error     = rx_err;
   assign if_b.rx_data      = rx_data;
   assign if_c.rx_interrupt = rx_int;
   assign if_c.rx_error     = rx_err;
   assign if_c.rx_data      = rx_data;

   uart_rx_frame_assembler #(
      .BYTE_W(8), .CHUNK_W(4), .NUM_CHUNKS(2), .MSB_FIRST(1'b1), .TIMEOUT_CYC(0)
   ) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (if_a.slave)
   );

   uart_rx_frame_assembler #(
      .BYTE_W(8), .CHUNK_W(4), .NUM_CHUNKS(4), .MSB_FIRST(1'b1), .TIMEOUT_CYC(10)
   ) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (if_b.slave)
   );

   uart_rx_frame_assembler #(
      .BYTE_W(8), .CHUNK_W(4), .NUM_CHUNKS(4), .MSB_FIRST(1'b0), .TIMEOUT_CYC(0)
   ) u_dut_c (
      .clk   (clk),
      .reset (reset),
      .bus   (if_c.slave)
   );

   logic [2:0]       obs_clr, obs_valid, obs_err, obs_busy;
   logic [2:0][15:0] obs_data;
   logic [2:0][2:0]  obs_cnt;

   assign obs_clr  = {if_c.clear_interrupt, if_b.clear_interrupt, if_a.clear_interrupt};
   assign obs_valid = {if_c.frame_valid, if_b.frame_valid, if_a.frame_valid};
   assign obs_err  = {if_c.frame_error, if_b.frame_error, if_a.frame_error};
   assign obs_busy = {if_c.busy, if_b.busy, if_a.busy};
   assign obs_data[0] = {8'h00, if_a.frame_data};
   assign obs_data[1] = if_b.frame_data;
   assign obs_data[2] = if_c.frame_data;
   assign obs_cnt[0]  = {1'b0, if_a.chunk_count};
   assign obs_cnt[1]  = if_b.chunk_count;
   assign obs_cnt[2]  = if_c.chunk_count;

   // Frame-level reference model: chunks collected so far and last completed frame.
   int unsigned m_n   [3];
   bit          m_msb [3];
   int unsigned m_tmo [3];
   int unsigned m_chunks [3][4];
   int unsigned m_cnt [3];
   logic [15:0] m_data [3];

   function automatic logic [15:0] pack(input int i);
      logic [15:0] f = 16'h0;
      for (int j = 0; j < int'(m_n[i]); j++) begin
         if (m_msb[i]) f = f | 16'(m_chunks[i][j] << (4 * (int'(m_n[i]) - 1 - j)));
         else          f = f | 16'(m_chunks[i][j] << (4 * j));
      end
      return f;
   endfunction

   task automatic chk(input string tag, input int inst, input logic [15:0] o,
                      input logic [15:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s[%0d]: observed=%0h expected=%0h", tag, inst, o, e);
      end
   endtask

   task automatic check_state(input string tag, input logic clr, input logic [2:0] ev,
                              input logic [2:0] ee);
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_clr"},   i, 16'(obs_clr[i]),   16'(clr));
         chk({tag, "_valid"}, i, 16'(obs_valid[i]), 16'(ev[i]));
         chk({tag, "_err"},   i, 16'(obs_err[i]),   16'(ee[i]));
         chk({tag, "_data"},  i, obs_data[i],       m_data[i]);
         chk({tag, "_cnt"},   i, 16'(obs_cnt[i]),   16'(m_cnt[i]));
         chk({tag, "_busy"},  i, 16'(obs_busy[i]),  16'(m_cnt[i] != 0));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         m_cnt[i]  = 0;
         m_data[i] = 16'h0;
      end
      check_state("reset", 1'b0, 3'b000, 3'b000);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Idle for 'gap' cycles, present one byte until acked, hold it 'hold' extra cycles, drop it.
   task automatic send_byte(input logic [7:0] d, input bit err, input int gap, input int hold);
      logic [2:0] ev, ee;
      for (int k = 1; k <= gap; k++) begin
         @(negedge clk);
         ee = 3'b000;
         for (int i = 0; i < 3; i++) begin
            if (m_tmo[i] != 0 && m_cnt[i] != 0 && k == int'(m_tmo[i])) begin
               ee[i]    = 1'b1;
               m_cnt[i] = 0;
            end
         end
         check_state("idle", 1'b0, 3'b000, ee);
      end
      rx_int  = 1'b1;
      rx_err  = err;
      rx_data = d;
      @(negedge clk);
      ev = 3'b000;
      ee = 3'b000;
      for (int i = 0; i < 3; i++) begin
         if (err) begin
            ee[i]    = 1'b1;
            m_cnt[i] = 0;
         end else begin
            m_chunks[i][m_cnt[i]] = {28'h0, d[3:0]};
            m_cnt[i]++;
            if (m_cnt[i] == m_n[i]) begin
               ev[i]     = 1'b1;
               m_data[i] = pack(i);
               m_cnt[i]  = 0;
            end
         end
      end
      check_state("ack", 1'b1, ev, ee);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check_state("hold", 1'b0, 3'b000, 3'b000);
      end
      rx_int = 1'b0;
      rx_err = 1'b0;
      @(negedge clk);
      check_state("low", 1'b0, 3'b000, 3'b000);
      if (hold == 0) @(negedge clk);
   endtask

   initial begin
      m_n   = '{2, 4, 4};
      m_msb = '{1'b1, 1'b1, 1'b0};
      m_tmo = '{0, 10, 0};
      for (int i = 0; i < 3; i++) begin
         m_cnt[i]  = 0;
         m_data[i] = 16'h0;
      end

      repeat (2) @(negedge clk);
      check_state("por", 1'b0, 3'b000, 3'b000);
      reset = 1'b1;
      @(negedge clk);

      // Four-chunk packing in both orders.
      send_byte(8'h01, 1'b0, 0, 0);
      send_byte(8'h02, 1'b0, 0, 0);
      send_byte(8'h03, 1'b0, 0, 0);
      send_byte(8'h04, 1'b0, 0, 0);
      chk("t2_msb_first", 1, obs_data[1], 16'h1234);
      chk("t2_lsb_first", 2, obs_data[2], 16'h4321);

      // Default nibble packing; upper bits ignored.
      send_byte(8'hA5, 1'b0, 0, 0);
      send_byte(8'h3C, 1'b0, 0, 0);
      chk("t1_data", 0, obs_data[0], 16'h005C);

      // Receiver error drops the partial frame; next frame is clean.
      send_byte(8'h07, 1'b0, 1, 0);
      send_byte(8'hFF, 1'b1, 2, 0);
      send_byte(8'h01, 1'b0, 0, 0);
      send_byte(8'h02, 1'b0, 0, 0);
      chk("t3_data", 0, obs_data[0], 16'h0012);

      // Timeout on B after 10 idle cycles; then a byte arriving exactly at the limit.
      send_byte(8'h09, 1'b0, 0, 0);
      send_byte(8'h06, 1'b0, 12, 0);
      chk("t4_b_data", 1, obs_data[1], 16'h1234);
      chk("t4_a_data", 0, obs_data[0], 16'h0096);
      send_byte(8'h05, 1'b0, 9, 0);

      // Interrupt held long after the ack: one capture only.
      send_byte(8'h0B, 1'b0, 0, 20);

      // Reset mid-frame, then a fresh frame with no stale chunk.
      do_reset();
      send_byte(8'h0D, 1'b0, 0, 0);
      do_reset();
      send_byte(8'h01, 1'b0, 0, 0);
      send_byte(8'h02, 1'b0, 0, 0);
      chk("t6_data", 0, obs_data[0], 16'h0012);

      // Randomized traffic against the model.
      for (int n = 0; n < 80; n++) begin
         send_byte(8'($urandom), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 12)),
                   int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
